// File: rtl/s298_scan_bist_ctrl_pkg.sv
// bist_pkg: shared state encoding and polynomial for the s298 logic-BIST controller.
package bist_pkg;
  localparam int SIG_W = 16;
  localparam logic [SIG_W-1:0] POLY16 = 16'hB400;
  typedef enum logic [2:0] {IDLE, INIT, LOAD0, SHIFT, CAPTURE, UNLOAD, DONE} state_t;
endpackage

// File: rtl/s298_scan_bist_ctrl_lfsr16.sv
// bist_lfsr16: 16-bit Fibonacci shift register with load and parallel XOR input.
// Zero XOR input gives a pattern generator; live input gives a MISR compactor.
import bist_pkg::*;
module bist_lfsr16 #(
  parameter logic [SIG_W-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_ld,
  input  logic [SIG_W-1:0] i_ld_val,
  input  logic [SIG_W-1:0] i_xin,
  output logic [SIG_W-1:0] o_q
);
  logic [SIG_W-1:0] r_q;
  logic [SIG_W-1:0] w_nxt;
  always_comb w_nxt = i_ld ? i_ld_val : i_en ? {r_q[SIG_W-2:0], ^(r_q & POLY16)} ^ i_xin : r_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_q <= RST_VAL;
    else r_q <= w_nxt;
  assign o_q = r_q;
endmodule

// File: rtl/s298_scan_bist_ctrl.sv
// s298_scan_bist_ctrl: logic-BIST sequencer driving the s298 scan chain.
// Outputs are decoded from registered state, so they change only on CK.
import bist_pkg::*;
module s298_scan_bist_ctrl #(
  parameter int             CHAIN_LEN    = 14,
  parameter int             NUM_PATTERNS = 256,
  parameter logic [SIG_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [2:0]       cut_pi,
  output logic             scan_en,
  output logic             scan_in,
  input  logic [5:0]       cut_po,
  input  logic             scan_out
);
  localparam int SCW = $clog2(CHAIN_LEN + 1);
  localparam int PCW = $clog2(NUM_PATTERNS + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(CHAIN_LEN - 1);
  localparam logic [PCW-1:0] PC_LAST = PCW'(NUM_PATTERNS - 1);
  state_t r_state;
  logic [SCW-1:0] r_sc;
  logic [PCW-1:0] r_pc;
  logic [SIG_W-1:0] w_lfsr, w_misr_x;
  logic w_init, w_load, w_cap, w_unl, w_shift;
  always_comb begin
    w_init   = r_state == INIT;
    w_load   = r_state == LOAD0 || r_state == SHIFT;
    w_cap    = r_state == CAPTURE;
    w_unl    = r_state == UNLOAD;
    w_shift  = r_state == SHIFT || w_unl;
    scan_en  = w_load || w_unl;
    scan_in  = w_load & w_lfsr[15];
    cut_pi   = w_cap ? w_lfsr[2:0] : 3'b0;
    busy     = !(r_state == IDLE || r_state == DONE);
    done     = r_state == DONE;
    pass     = done && signature == GOLDEN_SIG;
    w_misr_x = w_cap ? {10'b0, cut_po} : {9'b0, scan_out, 6'b0};
  end
  bist_lfsr16 #(.RST_VAL(LFSR_SEED)) u_gen (
    .i_clk(CK), .i_rst(RST), .i_en(w_load || w_cap), .i_ld(w_init),
    .i_ld_val(LFSR_SEED), .i_xin('0), .o_q(w_lfsr)
  );
  // LOAD0 leaves the MISR idle: the chain still holds power-up garbage
  bist_lfsr16 #(.RST_VAL('0)) u_misr (
    .i_clk(CK), .i_rst(RST), .i_en(w_shift || w_cap), .i_ld(w_init),
    .i_ld_val('0), .i_xin(w_misr_x), .o_q(signature)
  );
  always_ff @(posedge CK or posedge RST)
    if (RST) begin
      r_state <= IDLE;
      r_sc    <= '0;
      r_pc    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: r_state <= start ? INIT : r_state;
        INIT: begin
          r_sc    <= '0;
          r_pc    <= '0;
          r_state <= LOAD0;
        end
        LOAD0, SHIFT, UNLOAD: begin
          r_sc    <= r_sc == SC_LAST ? '0 : r_sc + 1'b1;
          r_state <= r_sc != SC_LAST ? r_state : r_state == UNLOAD ? DONE : CAPTURE;
        end
        CAPTURE: begin
          r_pc    <= r_pc + 1'b1;
          r_state <= r_pc == PC_LAST ? UNLOAD : SHIFT;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
